// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag indices, FSM encoding and flag-mask helper for alu_pipe
package alu_pkg;

   localparam logic [2:0] OP_ADD    = 3'b000;
   localparam logic [2:0] OP_SUB    = 3'b001;
   localparam logic [2:0] OP_XOR    = 3'b010;
   localparam logic [2:0] OP_RED    = 3'b011;
   localparam logic [2:0] OP_SLL    = 3'b100;
   localparam logic [2:0] OP_SRA    = 3'b101;
   localparam logic [2:0] OP_ROR    = 3'b110;
   localparam logic [2:0] OP_PADDSB = 3'b111;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   function automatic logic is_shift(input logic [2:0] op);
      return (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
   endfunction

   // Bit set = this flag takes the ALU value when the op completes.
   function automatic logic [2:0] flag_mask(input logic [2:0] op);
      logic [2:0] m;
      m = 3'b000;
      case (op)
         OP_ADD, OP_SUB:         m = 3'b111;
         OP_XOR, OP_SLL,
         OP_SRA, OP_ROR:         m[FLAG_Z] = 1'b1;
         default:                m = 3'b000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - single-cycle ALU results, one-bit shift/rotate step and overflow indication
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       step_op_i,
   input  logic [WIDTH-1:0] step_in_i,
   output logic [WIDTH-1:0] res_o,
   output logic             ovf_o,
   output logic [WIDTH-1:0] step_o
);

   localparam int NB = WIDTH / 8;
   localparam int NL = WIDTH / 4;
   localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic             add_ovf;
   logic             sub_ovf;
   logic [WIDTH-1:0] add_sat;
   logic [WIDTH-1:0] sub_sat;
   logic [WIDTH-1:0] red;
   logic [WIDTH-1:0] padd;
   logic [4:0]       lane;

   // One extra bit keeps the true sign, so it picks the clamp direction.
   assign add_w   = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
   assign sub_w   = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};
   assign add_ovf = add_w[WIDTH] ^ add_w[WIDTH-1];
   assign sub_ovf = sub_w[WIDTH] ^ sub_w[WIDTH-1];
   assign add_sat = add_ovf ? (add_w[WIDTH] ? SMIN : SMAX) : add_w[WIDTH-1:0];
   assign sub_sat = sub_ovf ? (sub_w[WIDTH] ? SMIN : SMAX) : sub_w[WIDTH-1:0];

   always_comb begin
      red = '0;
      for (int i = 0; i < NB; i++) begin
         red = red + WIDTH'($signed(a_i[8*i +: 8])) + WIDTH'($signed(b_i[8*i +: 8]));
      end
   end

   always_comb begin
      padd = '0;
      lane = '0;
      for (int l = 0; l < NL; l++) begin
         lane = {a_i[4*l+3], a_i[4*l +: 4]} + {b_i[4*l+3], b_i[4*l +: 4]};
         if (lane[4] != lane[3]) begin
            padd[4*l +: 4] = lane[4] ? 4'h8 : 4'h7;
         end else begin
            padd[4*l +: 4] = lane[3:0];
         end
      end
   end

   always_comb begin
      res_o = a_i;
      ovf_o = 1'b0;
      case (op_i)
         OP_ADD: begin
            res_o = add_sat;
            ovf_o = add_ovf;
         end
         OP_SUB: begin
            res_o = sub_sat;
            ovf_o = sub_ovf;
         end
         OP_XOR:    res_o = a_i ^ b_i;
         OP_RED:    res_o = red;
         OP_PADDSB: res_o = padd;
         default:   res_o = a_i;
      endcase
   end

   always_comb begin
      step_o = step_in_i;
      case (step_op_i)
         OP_SLL:  step_o = {step_in_i[WIDTH-2:0], 1'b0};
         OP_SRA:  step_o = {step_in_i[WIDTH-1], step_in_i[WIDTH-1:1]};
         OP_ROR:  step_o = {step_in_i[0], step_in_i[WIDTH-1:1]};
         default: step_o = step_in_i;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked execute-stage ALU with iterative shifter and {N,V,Z} flag register
module alu_pipe
   import alu_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [2:0]       flag,
   input  logic             flag_wr,
   input  logic [2:0]       flag_wdata
);

   logic [1:0]       state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [2:0]       flag_q, flag_d;

   logic [WIDTH-1:0] res;
   logic             ovf;
   logic [WIDTH-1:0] step;
   logic             accept;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] fin_val;
   logic             fin_ovf;
   logic [2:0]       fin_op;
   logic [2:0]       fin_mask;
   logic [2:0]       fresh;
   logic [2:0]       base_flag;
   logic [2:0]       merged_flag;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .op_i      (op),
      .a_i       (in1),
      .b_i       (in2),
      .step_op_i (op_q),
      .step_in_i (sh_q),
      .res_o     (res),
      .ovf_o     (ovf),
      .step_o    (step)
   );

   assign in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
   assign accept    = in_valid && in_ready;
   assign shamt     = in2[SHW-1:0];
   assign out_valid = (state_q == ST_DONE);
   assign alu_out   = out_q;
   assign flag      = flag_q;

   // Completion value is the shifter output in SHIFT, otherwise the single-cycle result.
   always_comb begin
      fin_val = res;
      fin_ovf = ovf;
      fin_op  = op;
      if (state_q == ST_SHIFT) begin
         fin_val = step;
         fin_ovf = 1'b0;
         fin_op  = op_q;
      end
      fin_mask           = flag_mask(fin_op);
      fresh              = '0;
      fresh[FLAG_N]      = fin_val[WIDTH-1];
      fresh[FLAG_V]      = fin_ovf;
      fresh[FLAG_Z]      = (fin_val == '0);
      base_flag          = flag_wr ? flag_wdata : flag_q;
      merged_flag        = (fin_mask & fresh) | (~fin_mask & base_flag);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      op_d    = op_q;
      out_d   = out_q;
      flag_d  = base_flag;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               if (is_shift(op) && (shamt != '0)) begin
                  sh_d    = in1;
                  cnt_d   = shamt;
                  op_d    = op;
                  state_d = ST_SHIFT;
               end else begin
                  out_d   = fin_val;
                  flag_d  = merged_flag;
                  state_d = ST_DONE;
               end
            end else if ((state_q == ST_DONE) && out_ready) begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sh_d  = step;
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               out_d   = fin_val;
               flag_d  = merged_flag;
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         op_q    <= '0;
         out_q   <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         op_q    <= op_d;
         out_q   <= out_d;
         flag_q  <= flag_d;
      end
   end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe against a behavioural model
module tb_alu_pipe;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] alu_out;
   logic [2:0]  flag;
   logic        flag_wr;
   logic [2:0]  flag_wdata;

   int          n_vec = 0;
   int          n_err = 0;
   logic [2:0]  exp_flag;

   always #5 clk = ~clk;

   alu_pipe #(.WIDTH(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .in1        (in1),
      .in2        (in2),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .flag       (flag),
      .flag_wr    (flag_wr),
      .flag_wdata (flag_wdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int x, input int lo, input int hi, output logic sat);
      sat = 1'b0;
      if (x > hi) begin sat = 1'b1; return hi; end
      if (x < lo) begin sat = 1'b1; return lo; end
      return x;
   endfunction

   // Reference: plain integer arithmetic on the architectural definition of each op.
   task automatic model(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic v, output int lat);
      int          s;
      int          k;
      logic        sat;
      logic [7:0]  bt;
      logic [3:0]  la, lb;
      logic [31:0] d;
      v   = 1'b0;
      k   = int'(b[3:0]);
      lat = 1;
      r   = '0;
      case (o)
         OP_ADD: begin
            s = clamp(int'($signed(a)) + int'($signed(b)), -32768, 32767, sat);
            r = s[15:0]; v = sat;
         end
         OP_SUB: begin
            s = clamp(int'($signed(a)) - int'($signed(b)), -32768, 32767, sat);
            r = s[15:0]; v = sat;
         end
         OP_XOR: r = a ^ b;
         OP_RED: begin
            s = 0;
            for (int i = 0; i < 2; i++) begin
               bt = a[8*i +: 8]; s += int'($signed(bt));
               bt = b[8*i +: 8]; s += int'($signed(bt));
            end
            r = s[15:0];
         end
         OP_PADDSB: begin
            for (int l = 0; l < 4; l++) begin
               la = a[4*l +: 4];
               lb = b[4*l +: 4];
               s = clamp(int'($signed(la)) + int'($signed(lb)), -8, 7, sat);
               r[4*l +: 4] = s[3:0];
            end
         end
         OP_SLL: begin r = a << k; lat = 1 + k; end
         OP_SRA: begin r = $signed(a) >>> k; lat = 1 + k; end
         default: begin
            d = {a, a} >> k;
            r = d[15:0];
            lat = 1 + k;
         end
      endcase
   endtask

   function automatic logic [2:0] next_flag(input logic [2:0] o, input logic [15:0] r, input logic v,
                                            input logic [2:0] base);
      logic [2:0] f;
      f = base;
      if (o == OP_ADD || o == OP_SUB) begin
         f = {r[15], v, r == 16'h0};
      end else if (o == OP_XOR || o == OP_SLL || o == OP_SRA || o == OP_ROR) begin
         f[0] = (r == 16'h0);
      end
      return f;
   endfunction

   logic [15:0] last_res;

   // Starts and ends just after a falling edge.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                        input int hold, input logic fwr, input logic [2:0] fwd);
      logic [15:0] r;
      logic        v;
      int          lat;
      int          seen;
      model(o, a, b, r, v, lat);
      exp_flag = next_flag(o, r, v, fwr ? fwd : exp_flag);
      last_res = r;
      in_valid = 1'b1; op = o; in1 = a; in2 = b;
      flag_wr = fwr; flag_wdata = fwd;
      out_ready = 1'b1;
      #1;
      check({tag, "_rdy"}, in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flag_wr  = 1'b0;
      if (hold > 0) out_ready = 1'b0;
      seen = 1;
      while (!out_valid && seen < 40) begin
         check({tag, "_busy"}, in_ready, 1'b0);
         @(negedge clk);
         seen++;
      end
      check({tag, "_lat"}, seen, lat);
      check({tag, "_res"}, alu_out, r);
      check({tag, "_flag"}, flag, exp_flag);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_v"}, out_valid, 1'b1);
         check({tag, "_hold_d"}, alu_out, r);
         check({tag, "_hold_rdy"}, in_ready, 1'b0);
      end
      out_ready = 1'b1;
   endtask

   task automatic expect_out(input string tag, input logic [15:0] r, input logic [2:0] f);
      check({tag, "_const_res"}, alu_out, r);
      check({tag, "_const_flag"}, flag, f);
   endtask

   initial begin
      logic [15:0] r;
      logic        v;
      int          lat;
      logic [2:0]  o;
      rst = 1'b1; in_valid = 1'b0; op = '0; in1 = '0; in2 = '0;
      out_ready = 1'b1; flag_wr = 1'b0; flag_wdata = '0;
      exp_flag = 3'b000;
      repeat (3) @(negedge clk);
      check("rst_rdy", in_ready, 1'b0);
      check("rst_valid", out_valid, 1'b0);
      check("rst_out", alu_out, 16'h0);
      check("rst_flag", flag, 3'b000);
      rst = 1'b0;
      #1;
      check("post_rst_rdy", in_ready, 1'b1);
      @(negedge clk);

      do_op("add_ovf", OP_ADD, 16'h7FF0, 16'h0020, 0, 1'b0, 3'b0);  expect_out("add_ovf", 16'h7FFF, 3'b010);
      do_op("sub", OP_SUB, 16'h0014, 16'h0005, 0, 1'b0, 3'b0);      expect_out("sub", 16'h000F, 3'b000);
      do_op("sub_ovf", OP_SUB, 16'h8000, 16'h0001, 0, 1'b0, 3'b0);  expect_out("sub_ovf", 16'h8000, 3'b110);
      do_op("xor_z", OP_XOR, 16'hABCD, 16'hABCD, 0, 1'b0, 3'b0);    expect_out("xor_z", 16'h0000, 3'b111);
      do_op("red", OP_RED, 16'hFF00, 16'h00FF, 0, 1'b0, 3'b0);      expect_out("red", 16'hFFFE, 3'b111);
      do_op("paddsb", OP_PADDSB, 16'h7777, 16'h1111, 0, 1'b0, 3'b0); expect_out("paddsb", 16'h7777, 3'b111);
      do_op("sll4", OP_SLL, 16'h1234, 16'h0004, 0, 1'b0, 3'b0);     expect_out("sll4", 16'h2340, 3'b110);
      do_op("sra15", OP_SRA, 16'h8000, 16'h000F, 0, 1'b0, 3'b0);    expect_out("sra15", 16'hFFFF, 3'b110);
      do_op("ror0", OP_ROR, 16'h0001, 16'h0000, 0, 1'b0, 3'b0);     expect_out("ror0", 16'h0001, 3'b110);
      do_op("hold", OP_ADD, 16'h0003, 16'h0004, 3, 1'b0, 3'b0);     expect_out("hold", 16'h0007, 3'b000);

      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; op = OP_ADD; in1 = 16'($urandom); in2 = 16'($urandom);
         model(OP_ADD, in1, in2, r, v, lat);
         exp_flag = next_flag(OP_ADD, r, v, exp_flag);
         #1;
         check("b2b_rdy", in_ready, 1'b1);
         @(negedge clk);
         check("b2b_valid", out_valid, 1'b1);
         check("b2b_res", alu_out, r);
         check("b2b_flag", flag, exp_flag);
      end
      in_valid = 1'b0;

      do_op("fwr_xor", OP_XOR, 16'h5A5A, 16'h5A5A, 0, 1'b1, 3'b101);
      expect_out("fwr_xor", 16'h0000, 3'b101);

      for (int i = 0; i < 150; i++) begin
         o = 3'($urandom_range(0, 7));
         do_op("rnd", o, 16'($urandom), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
               $urandom_range(0, 7) == 0, 3'($urandom));
      end

      do_op("pre_rst", OP_ADD, 16'h0001, 16'h0002, 0, 1'b0, 3'b0);
      @(negedge clk);
      flag_wr = 1'b1; flag_wdata = 3'b111;
      @(negedge clk);
      flag_wr = 1'b0;
      exp_flag = 3'b111;
      check("fwr_idle", flag, 3'b111);

      in_valid = 1'b1; op = OP_SLL; in1 = 16'h00FF; in2 = 16'h0008;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", out_valid, 1'b0);
      check("midrst_flag", flag, 3'b000);
      check("midrst_out", alu_out, 16'h0);
      rst = 1'b0;
      exp_flag = 3'b000;
      #1;
      check("midrst_rdy", in_ready, 1'b1);
      @(negedge clk);
      check("midrst_quiet", out_valid, 1'b0);
      do_op("after_rst", OP_ADD, 16'h0001, 16'h0001, 0, 1'b0, 3'b0);
      expect_out("after_rst", 16'h0002, 3'b000);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
